uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. Captures each completed frame (data byte plus stop-bit sample), tags it with a framing-error flag, and queues it in a first-word-fall-through FIFO. The consumer pops with a valid/ready handshake. Overrun status is sticky, and the block keeps a saturating framing-error count for host-side diagnostics.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥ 2
- ADDR_W, 4, log2(DEPTH)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- i_rx_done  in  1  one-cycle pulse; frame complete
- i_rx_data  in  8  received byte; valid in the i_rx_done cycle
- i_rx_stop_bit  in  1  sampled stop bit; valid in the cycle after i_rx_done
- i_ready  in  1  consumer accepts head entry
- i_clr  in  1  clears o_overrun and o_ferr_cnt
- o_valid  out  1  FIFO non-empty; head entry presented
- o_data  out  8  head entry byte
- o_frame_err  out  1  head entry stop bit was 0
- o_count  out  ADDR_W+1  entries held, 0..DEPTH
- o_full  out  1  o_count == DEPTH
- o_overrun  out  1  sticky; a frame was dropped because the FIFO was full
- o_ferr_cnt  out  8  saturating count of frames with stop bit 0

## Operation
- Capture stage: on i_rx_done, latch i_rx_data into stage register and set stage_vld.
- Commit cycle (stage_vld=1): sample i_rx_stop_bit and form entry {ferr = ~i_rx_stop_bit, data}.
- If the FIFO has room, write the entry at wr_ptr. The FIFO has room when count < DEPTH, or when a pop occurs in the same cycle.
- Otherwise drop the entry and set o_overrun.
- Framing-error count: if ferr=1, o_ferr_cnt increments, saturating at 255. Dropped frames are counted too.
- Stage behaves as a 1-deep pipeline. A new i_rx_done in the commit cycle reloads the stage while the old entry commits. Pulses 1 cycle apart are legal.
- Pop: o_valid && i_ready advances rd_ptr. i_ready while empty has no effect.
- Pointers are ADDR_W bits and wrap modulo DEPTH. o_count tracks occupancy; simultaneous write and pop leave it unchanged.
- i_clr zeroes o_overrun and o_ferr_cnt. If a set or increment event occurs in the same cycle, the event wins: o_overrun=1 or o_ferr_cnt=1.
- FIFO contents, o_count, and o_valid are unaffected by i_clr.
- Reset mid-operation:
  - Discards the stage and all entries.
  - The stop-bit sample of an in-flight frame is ignored.
  - An i_rx_done asserted together with reset is ignored.

## Timing
- Reset values: o_valid=0, o_data=0, o_frame_err=0, o_count=0, o_full=0, o_overrun=0, o_ferr_cnt=0, stage_vld=0, pointers=0.
- i_rx_done in cycle T → entry written at end of T+1. o_valid=1 from T+2 if the FIFO was empty.
- o_data/o_frame_err are read combinationally from storage at rd_ptr (FWFT); they are 0 when empty. The next entry appears the cycle after a pop.
- o_count, o_full, and o_overrun update at the clock edge of the write or pop, i.e. visible the following cycle.
- Throughput: one write and one pop per cycle, sustained.

## Structure
- Package uart_pkg:
  - UART_DATA_W = 8
  - packed struct uart_rx_entry_t {logic ferr; logic [7:0] data}
  - FERR_CNT_MAX = 8'hFF
- Sub-module uart_fifo_mem: DEPTH×9 register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). No reset on storage.
- Top level holds the capture stage, pointers, count, and status logic.

## Test plan
- Single frame:
  - Stimulus: i_rx_done with 0xA5 at T, stop bit 1 at T+1.
  - Response: o_valid=1 at T+2 with o_data=0xA5, o_frame_err=0, o_count=1. After pop, o_valid=0 and o_count=0.
- Framing error:
  - Stimulus: frame 0x3C, stop bit 0.
  - Response: o_frame_err=1 at head, o_ferr_cnt=1. Repeated 300 times, o_ferr_cnt saturates at 255.
- Fill and overrun:
  - Stimulus: 17 frames 0x00..0x10 with i_ready=0 (DEPTH=16).
  - Response: o_full=1 after 16, o_count=16. 17th dropped, o_overrun=1. Drain yields 0x00..0x0F in order.
- Full + simultaneous pop:
  - Stimulus: FIFO full, commit cycle coincides with i_ready=1.
  - Response: entry accepted, o_overrun stays 0, o_count stays 16, order preserved across pointer wrap.
- Back-to-back:
  - Stimulus: i_rx_done at T and T+1 (0x11, 0x22), stop bits 1 and 0.
  - Response: two entries, 0x11 ferr=0 then 0x22 ferr=1.
- Clear/reset races:
  - i_clr in the same cycle as an overrun drop → o_overrun=1.
  - reset asserted in a commit cycle with 3 entries held → all outputs return to reset values next cycle, and no entry is written.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive buffer.
//   UART_DATA_W      - width of a received data byte
//   uart_rx_entry_t  - one FIFO entry: framing-error flag plus data byte
//   FERR_CNT_MAX     - saturation value of the framing-error counter
//   sat_inc()        - saturating increment for the framing-error counter
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef struct packed {
        logic                   ferr;
        logic [UART_DATA_W-1:0] data;
    } uart_rx_entry_t;

    localparam logic [7:0] FERR_CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == FERR_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x 9-bit entry storage for the receive FIFO.
//   clk    - system clock
//   we     - write enable
//   waddr  - write address
//   wdata  - entry to write
//   raddr  - read address
//   rdata  - entry at raddr, read combinationally so the head falls through
// Storage has no reset; the owner qualifies rdata with its own valid flag.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  uart_rx_entry_t        wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output uart_rx_entry_t        rdata
);

    uart_rx_entry_t mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind a UART receiver.
// A one-deep capture stage holds the byte for one cycle so the stop-bit
// sample (which arrives a cycle after rx_done) can be attached as a framing
// error flag; the completed entry is then queued in a first-word-fall-through
// FIFO popped with valid/ready.
//   clk, reset     - clock and synchronous active-high reset
//   i_rx_done      - frame-complete pulse, i_rx_data valid in the same cycle
//   i_rx_data      - received byte
//   i_rx_stop_bit  - stop-bit sample, valid the cycle after i_rx_done
//   i_ready        - consumer accepts the head entry
//   i_clr          - clears o_overrun and o_ferr_cnt
//   o_valid        - FIFO non-empty
//   o_data         - head byte (0 when empty)
//   o_frame_err    - head entry had stop bit 0 (0 when empty)
//   o_count        - occupancy 0..DEPTH
//   o_full         - occupancy == DEPTH
//   o_overrun      - sticky: a frame was dropped on a full FIFO
//   o_ferr_cnt     - saturating count of frames with a bad stop bit
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rx_done,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_stop_bit,
    input  logic              i_ready,
    input  logic              i_clr,
    output logic              o_valid,
    output logic [7:0]        o_data,
    output logic              o_frame_err,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_overrun,
    output logic [7:0]        o_ferr_cnt
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

    logic                   stage_vld_reg;
    logic [7:0]             stage_data_reg;
    logic [ADDR_W-1:0]      wr_ptr_reg;
    logic [ADDR_W-1:0]      rd_ptr_reg;
    logic [ADDR_W:0]        count_reg;
    logic [ADDR_W:0]        count_next;
    logic                   overrun_reg;
    logic                   overrun_next;
    logic [7:0]             ferr_cnt_reg;
    logic [7:0]             ferr_cnt_next;

    uart_rx_entry_t         wr_entry;
    uart_rx_entry_t         rd_entry;
    logic                   commit;
    logic                   pop;
    logic                   has_room;
    logic                   wr_en;
    logic                   drop;

    // The stage is committed in the cycle after capture, which is exactly
    // when the stop-bit sample is valid.
    assign commit   = stage_vld_reg;
    assign wr_entry = '{ferr: ~i_rx_stop_bit, data: stage_data_reg};

    assign pop      = o_valid && i_ready;
    // A pop in the same cycle frees the slot the write needs.
    assign has_room = (count_reg < COUNT_FULL) || pop;
    assign wr_en    = commit && has_room;
    assign drop     = commit && !has_room;

    always_comb begin
        count_next = count_reg;
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + (ADDR_W+1)'(1);
            2'b01:   count_next = count_reg - (ADDR_W+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Set/increment events take priority over a simultaneous clear.
    always_comb begin
        overrun_next = overrun_reg;
        if (drop) begin
            overrun_next = 1'b1;
        end else if (i_clr) begin
            overrun_next = 1'b0;
        end
    end

    always_comb begin
        ferr_cnt_next = ferr_cnt_reg;
        if (commit && wr_entry.ferr) begin
            ferr_cnt_next = i_clr ? 8'd1 : sat_inc(ferr_cnt_reg);
        end else if (i_clr) begin
            ferr_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_vld_reg  <= 1'b0;
            stage_data_reg <= 8'd0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overrun_reg    <= 1'b0;
            ferr_cnt_reg   <= 8'd0;
        end else begin
            stage_vld_reg <= i_rx_done;
            if (i_rx_done) begin
                stage_data_reg <= i_rx_data;
            end
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            count_reg    <= count_next;
            overrun_reg  <= overrun_next;
            ferr_cnt_reg <= ferr_cnt_next;
        end
    end

    // Write is gated by reset so an entry committing during reset is lost.
    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en && !reset),
        .waddr (wr_ptr_reg),
        .wdata (wr_entry),
        .raddr (rd_ptr_reg),
        .rdata (rd_entry)
    );

    assign o_valid     = (count_reg != '0);
    assign o_data      = o_valid ? rd_entry.data : 8'd0;
    assign o_frame_err = o_valid && rd_entry.ferr;
    assign o_count     = count_reg;
    assign o_full      = (count_reg == COUNT_FULL);
    assign o_overrun   = overrun_reg;
    assign o_ferr_cnt  = ferr_cnt_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo. Directed scenarios
// plus a randomized run, all checked against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_rx_done = 1'b0;
    logic [7:0]        i_rx_data = 8'd0;
    logic              i_rx_stop_bit = 1'b1;
    logic              i_ready = 1'b0;
    logic              i_clr = 1'b0;
    logic              o_valid;
    logic [7:0]        o_data;
    logic              o_frame_err;
    logic [ADDR_W:0]   o_count;
    logic              o_full;
    logic              o_overrun;
    logic [7:0]        o_ferr_cnt;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_rx_done     (i_rx_done),
        .i_rx_data     (i_rx_data),
        .i_rx_stop_bit (i_rx_stop_bit),
        .i_ready       (i_ready),
        .i_clr         (i_clr),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_frame_err   (o_frame_err),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_overrun     (o_overrun),
        .o_ferr_cnt    (o_ferr_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of {ferr, data}, pending frame, status.
    logic [8:0] mq [$];
    bit         m_stage_vld = 1'b0;
    logic [7:0] m_stage_data = 8'd0;
    bit         m_overrun = 1'b0;
    int         m_ferr_cnt = 0;

    wire [24:0] act_vec = {o_valid, o_data, o_frame_err, o_count, o_full, o_overrun, o_ferr_cnt};

    function automatic logic [24:0] exp_vec();
        logic [8:0] head;
        logic       vld;
        vld  = (mq.size() != 0);
        head = vld ? mq[0] : 9'd0;
        return {vld, head[7:0], head[8], 5'(mq.size()), (mq.size() == DEPTH),
                m_overrun, 8'(m_ferr_cnt)};
    endfunction

    // Apply the current inputs to the model for one clock, then advance the DUT.
    task automatic step();
        bit drop;
        bit fe;
        drop = 1'b0;
        fe   = 1'b0;
        if (reset) begin
            mq.delete();
            m_stage_vld = 1'b0;
            m_overrun   = 1'b0;
            m_ferr_cnt  = 0;
        end else begin
            if (mq.size() != 0 && i_ready) void'(mq.pop_front());
            if (m_stage_vld) begin
                fe = !i_rx_stop_bit;
                if (mq.size() < DEPTH) mq.push_back({fe, m_stage_data});
                else drop = 1'b1;
            end
            if (drop) m_overrun = 1'b1;
            else if (i_clr) m_overrun = 1'b0;
            if (fe) m_ferr_cnt = i_clr ? 1 : ((m_ferr_cnt < 255) ? m_ferr_cnt + 1 : 255);
            else if (i_clr) m_ferr_cnt = 0;
            m_stage_vld = i_rx_done;
            if (i_rx_done) m_stage_data = i_rx_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        $display("[TB] frame data=0x%02h stop=%0b", data, stop);
        i_rx_done = 1'b1;
        i_rx_data = data;
        step();
        i_rx_done     = 1'b0;
        i_rx_stop_bit = stop;
        step();
        i_rx_stop_bit = 1'b1;
    endtask

    task automatic clear_status();
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
    endtask

    task automatic drain();
        i_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH && mq.size() != 0; k++) step();
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_tests++;
        if (act_vec !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", act_vec, 25'd0);
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (o_valid !== 1'b0 || o_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%0b count=%0d expected 0/0", o_valid, o_count);
        end
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b1);
        n_tests++;
        if (o_valid !== 1'b1 || o_data !== 8'hA5 || o_frame_err !== 1'b0 || o_count !== 5'd1) begin
            n_fail++;
            $display("FAIL single_head: valid=%0b data=%h ferr=%0b count=%0d expected 1/a5/0/1",
                     o_valid, o_data, o_frame_err, o_count);
        end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0 || o_count !== 5'd0 || o_data !== 8'h00) begin
            n_fail++;
            $display("FAIL single_pop: valid=%0b count=%0d data=%h expected 0/0/00",
                     o_valid, o_count, o_data);
        end
    endtask

    task automatic test_ferr_sat();
        clear_status();
        send_frame(8'h3C, 1'b0);
        n_tests++;
        if (o_frame_err !== 1'b1 || o_data !== 8'h3C || o_ferr_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL ferr_head: ferr=%0b data=%h cnt=%0d expected 1/3c/1",
                     o_frame_err, o_data, o_ferr_cnt);
        end
        drain();
        // Continuous back-to-back bad frames, consumer always ready.
        i_ready       = 1'b1;
        i_rx_done     = 1'b1;
        i_rx_data     = 8'h3C;
        i_rx_stop_bit = 1'b0;
        for (int k = 0; k < 300; k++) step();
        i_rx_done = 1'b0;
        step();
        i_rx_stop_bit = 1'b1;
        n_tests++;
        if (o_ferr_cnt !== 8'd255 || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL ferr_saturate: cnt=%0d expected 255 (vec got %h expected %h)",
                     o_ferr_cnt, act_vec, exp_vec());
        end
        drain();
    endtask

    task automatic test_fill_overrun();
        clear_status();
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == DEPTH - 1) begin
                n_tests++;
                if (o_full !== 1'b1 || o_count !== 5'd16 || o_overrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_full: full=%0b count=%0d ovr=%0b expected 1/16/0",
                             o_full, o_count, o_overrun);
                end
            end
        end
        n_tests++;
        if (o_overrun !== 1'b1 || o_count !== 5'd16) begin
            n_fail++;
            $display("FAIL fill_overrun: ovr=%0b count=%0d expected 1/16", o_overrun, o_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (o_valid !== 1'b1 || o_data !== 8'(i)) begin
                n_fail++;
                $display("FAIL fill_drain_%0d: valid=%0b data=%h expected 1/%h", i, o_valid, o_data, 8'(i));
            end
            i_ready = 1'b1;
            step();
            i_ready = 1'b0;
        end
        n_tests++;
        if (o_valid !== 1'b0 || o_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_empty: valid=%0b ovr=%0b expected 0/1", o_valid, o_overrun);
        end
    endtask

    task automatic test_full_pop();
        clear_status();
        for (int i = 0; i < DEPTH; i++) send_frame(8'h40 + 8'(i), 1'b1);
        i_rx_done = 1'b1;
        i_rx_data = 8'h50;
        step();
        i_rx_done     = 1'b0;
        i_rx_stop_bit = 1'b1;
        i_ready       = 1'b1;
        step();
        i_ready = 1'b0;
        n_tests++;
        if (o_overrun !== 1'b0 || o_count !== 5'd16 || o_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_status: ovr=%0b count=%0d full=%0b expected 0/16/1",
                     o_overrun, o_count, o_full);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            n_tests++;
            if (o_valid !== 1'b1 || o_data !== 8'h40 + 8'(i)) begin
                n_fail++;
                $display("FAIL full_pop_order_%0d: data=%h expected %h", i, o_data, 8'h40 + 8'(i));
            end
            i_ready = 1'b1;
            step();
            i_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        clear_status();
        i_rx_done = 1'b1;
        i_rx_data = 8'h11;
        step();
        i_rx_data     = 8'h22;
        i_rx_stop_bit = 1'b1;
        step();
        i_rx_done     = 1'b0;
        i_rx_stop_bit = 1'b0;
        step();
        i_rx_stop_bit = 1'b1;
        n_tests++;
        if (o_count !== 5'd2 || o_data !== 8'h11 || o_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: count=%0d data=%h ferr=%0b expected 2/11/0",
                     o_count, o_data, o_frame_err);
        end
        i_ready = 1'b1;
        step();
        n_tests++;
        if (o_data !== 8'h22 || o_frame_err !== 1'b1 || o_ferr_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL b2b_second: data=%h ferr=%0b cnt=%0d expected 22/1/1",
                     o_data, o_frame_err, o_ferr_cnt);
        end
        step();
        i_ready = 1'b0;
    endtask

    task automatic test_clr_race();
        clear_status();
        for (int i = 0; i < DEPTH; i++) send_frame(8'h60 + 8'(i), 1'b1);
        i_rx_done = 1'b1;
        i_rx_data = 8'h77;
        step();
        i_rx_done = 1'b0;
        i_clr     = 1'b1;
        step();
        i_clr = 1'b0;
        n_tests++;
        if (o_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_overrun: ovr=%0b expected 1", o_overrun);
        end
        clear_status();
        n_tests++;
        if (o_overrun !== 1'b0 || o_count !== 5'd16 || o_data !== 8'h60) begin
            n_fail++;
            $display("FAIL clr_alone: ovr=%0b count=%0d data=%h expected 0/16/60",
                     o_overrun, o_count, o_data);
        end
        for (int i = 0; i < 3; i++) send_frame(8'h80, 1'b0);
        i_rx_done = 1'b1;
        i_rx_data = 8'h81;
        step();
        i_rx_done     = 1'b0;
        i_rx_stop_bit = 1'b0;
        i_clr         = 1'b1;
        step();
        i_clr         = 1'b0;
        i_rx_stop_bit = 1'b1;
        n_tests++;
        if (o_ferr_cnt !== 8'd1 || o_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_ferr: cnt=%0d ovr=%0b expected 1/1", o_ferr_cnt, o_overrun);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(8'hC0 + 8'(i), 1'b0);
        n_tests++;
        if (o_count !== 5'd3) begin
            n_fail++;
            $display("FAIL rmid_held: count=%0d expected 3", o_count);
        end
        i_rx_done = 1'b1;
        i_rx_data = 8'h99;
        step();
        // Commit cycle of 0x99, with a new rx_done pulse coinciding with reset.
        reset         = 1'b1;
        i_rx_data     = 8'h55;
        i_rx_stop_bit = 1'b1;
        step();
        reset     = 1'b0;
        i_rx_done = 1'b0;
        n_tests++;
        if (act_vec !== 25'd0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got %h expected %h", act_vec, 25'd0);
        end
        step();
        step();
        n_tests++;
        if (o_valid !== 1'b0 || o_count !== 5'd0) begin
            n_fail++;
            $display("FAIL rmid_no_write: valid=%0b count=%0d expected 0/0", o_valid, o_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 499) == 0);
            i_rx_done     = $urandom_range(0, 1);
            i_rx_data     = 8'($urandom);
            i_rx_stop_bit = ($urandom_range(0, 3) != 0);
            i_ready       = ($urandom_range(0, 2) == 0);
            i_clr         = ($urandom_range(0, 39) == 0);
            step();
            n_tests++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h expected %h", c, act_vec, exp_vec());
            end
        end
        reset     = 1'b0;
        i_rx_done = 1'b0;
        i_clr     = 1'b0;
        i_ready   = 1'b0;
        i_rx_stop_bit = 1'b1;
    endtask

    initial begin
        step();
        step();
        test_reset();
        test_single();
        test_ferr_sat();
        test_fill_overrun();
        test_full_pop();
        test_back_to_back();
        test_clr_race();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
